// File: rtl/branch_predict_unit_pkg.sv
// Shared control encodings for the branch prediction unit: PC-mux selects,
// jump classes from the control decoder and the conditional-branch opcodes.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ         = 3'b000,
    SEL_PRED        = 3'b001,
    SEL_ID_TARGET   = 3'b010,
    SEL_JUMP_IMM    = 3'b011,
    SEL_JUMP_REG    = 3'b100,
    SEL_ID_FALLTHRU = 3'b101
  } next_pc_sel_e;

  localparam logic [2:0] JS_J    = 3'b010;
  localparam logic [2:0] JS_JAL  = 3'b111;
  localparam logic [2:0] JS_JR   = 3'b011;
  localparam logic [2:0] JS_JALR = 3'b100;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  function automatic logic is_jump_imm(input logic [2:0] js);
    return (js == JS_J) || (js == JS_JAL);
  endfunction

  function automatic logic is_jump_reg(input logic [2:0] js);
    return (js == JS_JR) || (js == JS_JALR);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF-lookup, ID-resolve and PC-redirect signals of the branch prediction unit.
interface branch_predict_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                if_valid;
  logic                if_is_branch;
  logic [PC_WIDTH-1:0] if_pc;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_target;

  logic                id_valid;
  logic                id_is_branch;
  logic [PC_WIDTH-1:0] id_pc;
  logic [PC_WIDTH-1:0] id_target;
  logic                id_taken;
  logic                id_pred_taken;
  logic [PC_WIDTH-1:0] id_pred_target;

  logic [2:0]          jump_signal;
  logic [2:0]          next_pc_sel;
  logic                if_flush;
  logic [31:0]         branch_cnt;
  logic [31:0]         mispred_cnt;

  modport master (
    output if_valid, if_is_branch, if_pc,
    output id_valid, id_is_branch, id_pc, id_target, id_taken,
    output id_pred_taken, id_pred_target, jump_signal,
    input  pred_taken, pred_target, next_pc_sel, if_flush,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_valid, if_is_branch, if_pc,
    input  id_valid, id_is_branch, id_pc, id_target, id_taken,
    input  id_pred_taken, id_pred_target, jump_signal,
    output pred_taken, pred_target, next_pc_sel, if_flush,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter for one BHT entry; resets to weakly-not-taken.
module branch_predict_unit_sat_counter #(
  parameter int CTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 inc_i,
  output logic [CTR_WIDTH-1:0] count_o
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX   = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_MAX >> 1;

  logic [CTR_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (inc_i && (count_q != CTR_MAX)) begin
        count_d = count_q + 1'b1;
      end else if (!inc_i && (count_q != '0)) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CTR_RESET;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB branch predictor with IF lookup, ID resolution,
// PC-mux select generation and branch/mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [IDX_W-1:0]    if_idx, id_idx;
  logic [TAG_W-1:0]    if_tag, id_tag;

  logic                btb_valid_q  [BHT_DEPTH];
  logic [TAG_W-1:0]    btb_tag_q    [BHT_DEPTH];
  logic [PC_WIDTH-1:0] btb_target_q [BHT_DEPTH];
  logic [CTR_WIDTH-1:0] ctr         [BHT_DEPTH];

  logic                resolve, btb_write, mispredict, lookup_hit, pred_taken;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;
  next_pc_sel_e        sel;
  logic                flush;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[PC_WIDTH-1:IDX_W+2];
  assign id_idx = bus.id_pc[IDX_W+1:2];
  assign id_tag = bus.id_pc[PC_WIDTH-1:IDX_W+2];

  assign resolve   = bus.id_valid & bus.id_is_branch;
  assign btb_write = resolve & bus.id_taken;

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      branch_predict_unit_sat_counter #(
        .CTR_WIDTH (CTR_WIDTH)
      ) u_sat_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (resolve && (id_idx == IDX_W'(gi))),
        .inc_i   (bus.id_taken),
        .count_o (ctr[gi])
      );
    end
  endgenerate

  // Taken branches allocate/refresh their BTB entry; not-taken ones leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else if (btb_write) begin
      btb_valid_q[id_idx]  <= 1'b1;
      btb_tag_q[id_idx]    <= id_tag;
      btb_target_q[id_idx] <= bus.id_target;
    end
  end

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lookup_hit = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
  assign pred_taken = bus.if_valid & bus.if_is_branch & lookup_hit
                    & ctr[if_idx][CTR_WIDTH-1];

  assign mispredict = resolve &
                      ((bus.id_taken != bus.id_pred_taken) |
                       (bus.id_taken & (bus.id_pred_target != bus.id_target)));

  always_comb begin
    sel   = SEL_SEQ;
    flush = 1'b0;
    if (is_jump_imm(bus.jump_signal)) begin
      sel   = SEL_JUMP_IMM;
      flush = 1'b1;
    end else if (is_jump_reg(bus.jump_signal)) begin
      sel   = SEL_JUMP_REG;
      flush = 1'b1;
    end else if (mispredict && bus.id_taken) begin
      sel   = SEL_ID_TARGET;
      flush = 1'b1;
    end else if (mispredict) begin
      sel   = SEL_ID_FALLTHRU;
      flush = 1'b1;
    end else if (pred_taken) begin
      sel   = SEL_PRED;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve) begin
      branch_cnt_d = sat_inc32(branch_cnt_q);
    end
    if (mispredict) begin
      mispred_cnt_d = sat_inc32(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_taken ? btb_target_q[if_idx] : '0;
  assign bus.next_pc_sel = sel;
  assign bus.if_flush    = flush;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: drives on the falling edge, checks
// combinational outputs 1 ns later and statistics after the rising edge.
module tb_branch_predict_unit;

  localparam int PCW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_WIDTH(PCW)) bus ();

  branch_predict_unit #(
    .PC_WIDTH  (PCW),
    .BHT_DEPTH (64),
    .CTR_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic idle();
    bus.if_valid       = 1'b0;
    bus.if_is_branch   = 1'b0;
    bus.if_pc          = '0;
    bus.id_valid       = 1'b0;
    bus.id_is_branch   = 1'b0;
    bus.id_pc          = '0;
    bus.id_target      = '0;
    bus.id_taken       = 1'b0;
    bus.id_pred_taken  = 1'b0;
    bus.id_pred_target = '0;
    bus.jump_signal    = 3'b000;
  endtask

  task automatic drive_if(input logic [31:0] pc);
    bus.if_valid     = 1'b1;
    bus.if_is_branch = 1'b1;
    bus.if_pc        = pc;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                          input logic ptaken, input logic [31:0] ptgt);
    bus.id_valid       = 1'b1;
    bus.id_is_branch   = 1'b1;
    bus.id_pc          = pc;
    bus.id_target      = tgt;
    bus.id_taken       = taken;
    bus.id_pred_taken  = ptaken;
    bus.id_pred_target = ptgt;
  endtask

  task automatic new_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_branch_cnt", bus.branch_cnt, 32'd0);
    check_val("rst_mispred_cnt", bus.mispred_cnt, 32'd0);

    // cold lookup
    new_cycle(); drive_if(32'h100); #1;
    check_val("cold_pred", bus.pred_taken, 32'd0);
    check_val("cold_sel", bus.next_pc_sel, 32'd0);
    check_val("cold_flush", bus.if_flush, 32'd0);

    // taken mispredict while same index is looked up: old state used
    new_cycle(); drive_if(32'h100); drive_id(32'h100, 32'h200, 1'b1, 1'b0, 32'h0); #1;
    check_val("mp_taken_sel", bus.next_pc_sel, 32'd2);
    check_val("mp_taken_flush", bus.if_flush, 32'd1);
    check_val("same_idx_old_pred", bus.pred_taken, 32'd0);

    new_cycle(); drive_if(32'h100); #1;
    check_val("hit_pred", bus.pred_taken, 32'd1);
    check_val("hit_target", bus.pred_target, 32'h200);
    check_val("hit_sel", bus.next_pc_sel, 32'd1);
    check_val("hit_flush", bus.if_flush, 32'd0);
    check_val("bcnt_1", bus.branch_cnt, 32'd1);
    check_val("mcnt_1", bus.mispred_cnt, 32'd1);

    // correct taken: counter 10 -> 11
    new_cycle(); drive_id(32'h100, 32'h200, 1'b1, 1'b1, 32'h200); #1;
    check_val("correct_sel", bus.next_pc_sel, 32'd0);

    // predicted taken, resolves not taken: 11 -> 10
    new_cycle(); drive_id(32'h100, 32'h104, 1'b0, 1'b1, 32'h200); #1;
    check_val("mp_nt_sel", bus.next_pc_sel, 32'd5);
    check_val("mp_nt_flush", bus.if_flush, 32'd1);
    check_val("bcnt_2", bus.branch_cnt, 32'd2);
    check_val("mcnt_2", bus.mispred_cnt, 32'd1);

    // counter 10 still predicts taken; second not-taken: 10 -> 01
    new_cycle(); drive_if(32'h100); drive_id(32'h100, 32'h104, 1'b0, 1'b1, 32'h200); #1;
    check_val("ctr10_pred", bus.pred_taken, 32'd1);
    check_val("mp_nt_over_pred_sel", bus.next_pc_sel, 32'd5);
    check_val("bcnt_3", bus.branch_cnt, 32'd3);
    check_val("mcnt_3", bus.mispred_cnt, 32'd2);

    new_cycle(); drive_if(32'h100); #1;
    check_val("ctr01_pred", bus.pred_taken, 32'd0);
    check_val("ctr01_target", bus.pred_target, 32'd0);
    check_val("ctr01_sel", bus.next_pc_sel, 32'd0);
    check_val("bcnt_4", bus.branch_cnt, 32'd4);
    check_val("mcnt_4", bus.mispred_cnt, 32'd3);

    // register jump with concurrent mispredict: jump wins, tables still update (01 -> 10)
    new_cycle(); bus.jump_signal = 3'b011; drive_id(32'h100, 32'h200, 1'b1, 1'b0, 32'h0); #1;
    check_val("jr_mp_sel", bus.next_pc_sel, 32'd4);
    check_val("jr_mp_flush", bus.if_flush, 32'd1);

    new_cycle(); drive_if(32'h100); #1;
    check_val("jr_mp_bcnt", bus.branch_cnt, 32'd5);
    check_val("jr_mp_mcnt", bus.mispred_cnt, 32'd4);
    check_val("jr_mp_ctr_upd", bus.pred_taken, 32'd1);

    // immediate jump over a predicted-taken lookup
    new_cycle(); bus.jump_signal = 3'b111; drive_if(32'h100); #1;
    check_val("jimm_sel", bus.next_pc_sel, 32'd3);
    check_val("jimm_flush", bus.if_flush, 32'd1);

    // id_valid low: no update, no redirect
    new_cycle(); drive_id(32'h100, 32'h300, 1'b0, 1'b1, 32'h200); bus.id_valid = 1'b0; #1;
    check_val("novalid_sel", bus.next_pc_sel, 32'd0);
    check_val("novalid_flush", bus.if_flush, 32'd0);

    new_cycle(); drive_if(32'h100); #1;
    check_val("novalid_bcnt", bus.branch_cnt, 32'd5);
    check_val("novalid_mcnt", bus.mispred_cnt, 32'd4);
    check_val("novalid_pred", bus.pred_taken, 32'd1);
    check_val("novalid_target", bus.pred_target, 32'h200);

    // same index, different tag: miss
    new_cycle(); drive_if(32'h200); #1;
    check_val("tag_miss_pred", bus.pred_taken, 32'd0);

    // target mismatch mispredict (10 -> 11), then taken at 11 saturates, then not-taken -> 10
    new_cycle(); drive_id(32'h100, 32'h300, 1'b1, 1'b1, 32'h200); #1;
    check_val("tgt_mp_sel", bus.next_pc_sel, 32'd2);
    new_cycle(); drive_id(32'h100, 32'h300, 1'b1, 1'b1, 32'h300); #1;
    check_val("sat_top_sel", bus.next_pc_sel, 32'd0);
    new_cycle(); drive_id(32'h100, 32'h104, 1'b0, 1'b1, 32'h300); #1;
    check_val("sat_top_nt_sel", bus.next_pc_sel, 32'd5);
    new_cycle(); drive_if(32'h100); #1;
    check_val("sat_top_pred", bus.pred_taken, 32'd1);
    check_val("new_target", bus.pred_target, 32'h300);
    check_val("bcnt_8", bus.branch_cnt, 32'd8);
    check_val("mcnt_6", bus.mispred_cnt, 32'd6);

    // reset pulse between clock edges
    new_cycle(); drive_if(32'h100); #1;
    rst = 1'b1; #1;
    check_val("midrst_bcnt", bus.branch_cnt, 32'd0);
    check_val("midrst_mcnt", bus.mispred_cnt, 32'd0);
    check_val("midrst_pred", bus.pred_taken, 32'd0);
    check_val("midrst_sel", bus.next_pc_sel, 32'd0);
    bus.jump_signal = 3'b100; #1;
    check_val("midrst_jr_sel", bus.next_pc_sel, 32'd4);
    check_val("midrst_jr_flush", bus.if_flush, 32'd1);
    bus.jump_signal = 3'b000;
    rst = 1'b0;

    new_cycle(); drive_if(32'h100); #1;
    check_val("post_rst_pred", bus.pred_taken, 32'd0);

    // counter reset value is 01: one taken makes it predict taken
    new_cycle(); drive_id(32'h100, 32'h180, 1'b1, 1'b0, 32'h0); #1;
    check_val("post_rst_mp_sel", bus.next_pc_sel, 32'd2);
    new_cycle(); drive_if(32'h100); #1;
    check_val("wnt_plus1_pred", bus.pred_taken, 32'd1);
    check_val("wnt_plus1_target", bus.pred_target, 32'h180);
    check_val("post_rst_bcnt", bus.branch_cnt, 32'd1);
    check_val("post_rst_mcnt", bus.mispred_cnt, 32'd1);

    // three not-taken from 10 saturate at 00
    for (int i = 0; i < 3; i++) begin
      new_cycle(); drive_id(32'h100, 32'h104, 1'b0, 1'b0, 32'h0);
    end
    new_cycle(); drive_if(32'h100); #1;
    check_val("sat_bot_pred", bus.pred_taken, 32'd0);
    check_val("sat_bot_bcnt", bus.branch_cnt, 32'd4);
    check_val("sat_bot_mcnt", bus.mispred_cnt, 32'd1);

    new_cycle(); drive_id(32'h100, 32'h180, 1'b1, 1'b0, 32'h0);
    new_cycle(); drive_if(32'h100); #1;
    check_val("sat_bot_inc1_pred", bus.pred_taken, 32'd0);
    new_cycle(); drive_id(32'h100, 32'h180, 1'b1, 1'b0, 32'h0);
    new_cycle(); drive_if(32'h100); #1;
    check_val("sat_bot_inc2_pred", bus.pred_taken, 32'd1);
    check_val("final_bcnt", bus.branch_cnt, 32'd6);
    check_val("final_mcnt", bus.mispred_cnt, 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
